// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the RX-to-ALU sequencer.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

endpackage

// File: rtl/rx_alu_sequencer.sv
// Pops operand A, operand B and opcode from a FWFT receive FIFO, drives the external ALU,
// and pushes the captured result into the transmit FIFO.
//
// state   | meaning
// GET_A   | idle; pop operand A when the RX FIFO has a word
// GET_B   | pop operand B
// GET_OP  | pop opcode word (low OP_W bits kept)
// EXEC    | ALU settled; capture result, flag unsupported opcode
// SEND    | push result once the TX FIFO has room
module rx_alu_sequencer
    import alu_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [DBIT-1:0] tx_data,
    output logic [DBIT-1:0] alu_a,
    output logic [DBIT-1:0] alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [DBIT-1:0] alu_result,
    output logic            busy,
    output logic            op_err
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_rx_rd;
    logic            w_tx_wr;
    logic [DBIT-1:0] r_alu_a;
    logic [DBIT-1:0] r_alu_b;
    logic [OP_W-1:0] r_alu_op;
    logic [DBIT-1:0] r_tx_data;

    function automatic logic op_valid(input logic [OP_W-1:0] op);
        return op inside {OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_OR),
                          OP_W'(OP_XOR), OP_W'(OP_NOR), OP_W'(OP_SRA), OP_W'(OP_SRL)};
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_rx_rd     = 1'b0;
        w_tx_wr     = 1'b0;
        case (r_state)
            ST_GET_A: begin
                if (!rx_empty) begin
                    w_rx_rd     = 1'b1;
                    w_state_nxt = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (!rx_empty) begin
                    w_rx_rd     = 1'b1;
                    w_state_nxt = ST_GET_OP;
                end
            end
            ST_GET_OP: begin
                if (!rx_empty) begin
                    w_rx_rd     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (!tx_full) begin
                    w_tx_wr     = 1'b1;
                    w_state_nxt = ST_GET_A;
                end
            end
            default: w_state_nxt = ST_GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_GET_A;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rx_rd && r_state == ST_GET_A)  r_alu_a  <= rx_data;
            if (w_rx_rd && r_state == ST_GET_B)  r_alu_b  <= rx_data;
            if (w_rx_rd && r_state == ST_GET_OP) r_alu_op <= rx_data[OP_W-1:0];
            // ALU output reflects the opcode registered on the previous edge
            if (r_state == ST_EXEC)              r_tx_data <= alu_result;
        end
    end

    // Strobes are combinational, so gate them so a FIFO never sees a pop/push during reset
    assign rx_rd   = w_rx_rd & ~reset;
    assign tx_wr   = w_tx_wr & ~reset;
    assign tx_data = r_tx_data;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_op  = r_alu_op;
    assign busy    = (r_state != ST_GET_A);
    assign op_err  = (r_state == ST_EXEC) && !op_valid(r_alu_op);

endmodule

// File: tb/tb_rx_alu_sequencer.sv
// Directed scoreboard bench for rx_alu_sequencer: FWFT RX FIFO model, behavioural ALU,
// and a monitor that checks every TX push against queued hand-computed results.
module tb_rx_alu_sequencer;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       op_err;

    logic [7:0] rxq[$];
    exp_t       sb[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         n_pops     = 0;
    int         n_pushes   = 0;
    int         err_cycles = 0;
    int         exp_pushes = 0;

    rx_alu_sequencer #(.DBIT(8), .OP_W(6)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result), .busy(busy), .op_err(op_err)
    );

    always #5 clk = ~clk;

    // Unsupported opcodes return a recognisable constant so forwarding is visible
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            6'h03:   alu_result = 8'($signed(alu_a) >>> alu_b[2:0]);
            6'h02:   alu_result = alu_a >> alu_b[2:0];
            default: alu_result = 8'h5A;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_rx();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        update_rx();
    endtask

    task automatic send_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp_data, input logic exp_err);
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        exp_pushes++;
        push_rx(a);
        push_rx(b);
        push_rx(op);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rx_drained(input string name);
        int n = 0;
        while (rxq.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_rx_drain_timeout"}, (rxq.size() == 0), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rxq.size() != 0 || sb.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk({name, "_idle_timeout"}, (rxq.size() == 0 && sb.size() == 0), 1);
        step();
    endtask

    // RX FIFO: pop the head word on an edge where the DUT strobed rx_rd
    initial begin
        logic pop;
        forever begin
            @(posedge clk);
            pop = rx_rd;
            #1;
            if (pop && rxq.size() > 0) void'(rxq.pop_front());
            update_rx();
        end
    end

    // Monitor: checks handshake rules and compares each push with the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) err_cycles = 0;
            if (rx_rd) begin
                n_pops++;
                chk("rx_rd_while_empty", rx_empty, 0);
            end
            if (op_err) err_cycles++;
            if (tx_wr) begin
                n_pushes++;
                chk("tx_wr_while_full", tx_full, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_push", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", tx_data, e.data);
                    chk("op_err_cycles", err_cycles, e.err);
                end
                err_cycles = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0, push0;
        reset   = 1'b1;
        tx_full = 1'b0;
        update_rx();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_tx_wr", tx_wr, 0);
        #1 reset = 1'b0;
        step();

        // 1: ADD, three pops one push
        pops0 = n_pops; push0 = n_pushes;
        send_txn(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
        wait_idle("t1");
        chk("t1_pops", n_pops - pops0, 3);
        chk("t1_pushes", n_pushes - push0, 1);

        // 2: SUB wraps
        send_txn(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
        wait_idle("t2");

        // Remaining opcodes back to back; upper opcode-word bits ignored (0xE0 -> ADD)
        send_txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0);
        send_txn(8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0);
        send_txn(8'h80, 8'h01, 8'h02, 8'h40, 1'b0);
        send_txn(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
        send_txn(8'h10, 8'h20, 8'hE0, 8'h30, 1'b0);
        wait_idle("table");

        // 3: four empty cycles between words; busy stays high once A is popped
        chk("t3_busy_idle", busy, 0);
        begin
            exp_t e;
            e.data = 8'h30; e.err = 1'b0;
            sb.push_back(e);
            exp_pushes++;
        end
        push_rx(8'hF0);
        wait_rx_drained("t3a");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_busy_gap_a", busy, 1);
            chk("t3_no_pop_gap_a", rx_rd, 0);
        end
        push_rx(8'h3C);
        wait_rx_drained("t3b");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_busy_gap_b", busy, 1);
        end
        push_rx(8'h24);
        wait_idle("t3");

        // 4: TX full for 10 cycles in SEND
        push0 = n_pushes;
        tx_full = 1'b1;
        send_txn(8'hA5, 8'h0F, 8'h26, 8'hAA, 1'b0);
        wait_rx_drained("t4");
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            chk("t4_tx_wr_held", tx_wr, 0);
            chk("t4_tx_data_held", tx_data, 8'hAA);
            chk("t4_busy", busy, 1);
            step();
        end
        tx_full = 1'b0;
        #1;
        chk("t4_tx_wr_release", tx_wr, 1);
        wait_idle("t4");
        chk("t4_pushes", n_pushes - push0, 1);

        // 5: unsupported opcode 0xFF -> 0x3F, op_err pulse, result forwarded
        send_txn(8'h12, 8'h34, 8'hFF, 8'h5A, 1'b1);
        wait_rx_drained("t5");
        chk("t5_alu_op", alu_op, 6'h3F);
        chk("t5_op_err", op_err, 1);
        wait_idle("t5");

        // 6: reset while waiting in GET_OP
        pops0 = n_pops; push0 = n_pushes;
        push_rx(8'h11);
        push_rx(8'h22);
        wait_rx_drained("t6");
        step();
        chk("t6_busy_pre", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_alu_op", alu_op, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_op_err", op_err, 0);
        push_rx(8'h07);
        #1;
        chk("t6_rx_rd_in_reset", rx_rd, 0);
        chk("t6_tx_wr_in_reset", tx_wr, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        begin
            exp_t e;
            e.data = 8'h10; e.err = 1'b0;
            sb.push_back(e);
            exp_pushes++;
        end
        push_rx(8'h09);
        push_rx(8'h20);
        wait_idle("t6");
        chk("t6_pops", n_pops - pops0, 5);
        chk("t6_pushes", n_pushes - push0, 1);

        repeat (5) step();
        chk("total_pushes", n_pushes, exp_pushes);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
